// File: rtl/bp_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Contents: fetch FSM state enum, PC width, default reset vector,
// the NOP instruction word and a word-alignment helper.
package bp_pkg;

   localparam int              PC_W         = 32;
   localparam logic [PC_W-1:0] RESET_PC_DEF = 32'hBFC00000;
   localparam logic [31:0]     NOP          = 32'h0;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,   // no request in flight
      FETCH = 2'd1,   // exactly one request outstanding
      HOLD  = 2'd2    // fetched word parked while IF/ID is stalled
   } fetch_state_t;

   function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
      return {a[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry skid buffer holding one fetched word (data, PC, prediction
// bit) while the IF/ID latch is stalled.
// Ports:
//   CLK, RESET          clock, async active-low reset
//   load                capture data/pc/pred, mark entry valid
//   clear               empty the entry (wins over load)
//   data, pc, pred      word to park
//   held_*              parked entry contents and its valid flag
module fetch_skid_buf
   import bp_pkg::*;
(
   input  logic            CLK,
   input  logic            RESET,
   input  logic            load,
   input  logic            clear,
   input  logic [31:0]     data,
   input  logic [PC_W-1:0] pc,
   input  logic            pred,
   output logic            held_valid,
   output logic [31:0]     held_data,
   output logic [PC_W-1:0] held_pc,
   output logic            held_pred
);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         held_valid <= 1'b0;
         held_data  <= NOP;
         held_pc    <= '0;
         held_pred  <= 1'b0;
      end else if (clear) begin
         held_valid <= 1'b0;
      end else if (load) begin
         held_valid <= 1'b1;
         held_data  <= data;
         held_pc    <= pc;
         held_pred  <= pred;
      end
   end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: issues one instruction-memory request at a time,
// delivers returned words to IF/ID, follows BTB predictions and flush
// redirects, and parks a word in a skid buffer when IF/ID stalls.
// Ports:
//   CLK, RESET                       clock, async active-low reset
//   take_Branch_IN_IF, take_Alt_PC_IN_IF   BTB prediction / redirect target
//   FLUSH_IN, STALL_IN               mispredict redirect, IF/ID backpressure
//   Imem_Req_OUT, Imem_Addr_OUT      memory request and word address
//   Imem_Ack_IN, Imem_Data_IN        memory response pulse and data
//   Instr_OUT_IF, Instr_PC_OUT_IF, Valid_OUT_IF, Pred_Taken_OUT_IF
//                                    instruction delivered to IF/ID
module fetch_pc_gen
   import bp_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC     = RESET_PC_DEF,
   parameter int              IMEM_LAT_MAX = 8
)(
   input  logic            CLK,
   input  logic            RESET,
   input  logic            take_Branch_IN_IF,
   input  logic [PC_W-1:0] take_Alt_PC_IN_IF,
   input  logic            FLUSH_IN,
   input  logic            STALL_IN,
   output logic            Imem_Req_OUT,
   output logic [PC_W-1:0] Imem_Addr_OUT,
   input  logic            Imem_Ack_IN,
   input  logic [31:0]     Imem_Data_IN,
   output logic [31:0]     Instr_OUT_IF,
   output logic [PC_W-1:0] Instr_PC_OUT_IF,
   output logic            Valid_OUT_IF,
   output logic            Pred_Taken_OUT_IF
);

   fetch_state_t    state, state_nxt;
   logic [PC_W-1:0] pc_q, pc_nxt;         // fetch PC (target of next/current request)
   logic [PC_W-1:0] stale_q, stale_nxt;   // bus address kept alive while killed
   logic            kill_q, kill_nxt;
   logic [PC_W-1:0] alt_pc, follow_pc;
   logic            out_load, out_from_skid, out_drop;
   logic            skid_load, skid_clear;
   logic            skid_valid, skid_pred;
   logic [31:0]     skid_data;
   logic [PC_W-1:0] skid_pc;

   assign alt_pc    = word_align(take_Alt_PC_IN_IF);
   assign follow_pc = take_Branch_IN_IF ? alt_pc : word_align(pc_q + 32'd4);

   assign Imem_Req_OUT  = (state == FETCH);
   assign Imem_Addr_OUT = kill_q ? stale_q : pc_q;

   // The prediction and next PC are taken on the ack edge of a word; when
   // that word has to be parked they travel with it through the skid.
   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc_q;
      stale_nxt     = stale_q;
      kill_nxt      = kill_q;
      out_load      = 1'b0;
      out_from_skid = 1'b0;
      out_drop      = 1'b0;
      skid_load     = 1'b0;
      skid_clear    = 1'b0;
      if (FLUSH_IN) begin
         state_nxt  = FETCH;
         pc_nxt     = alt_pc;
         out_drop   = 1'b1;
         skid_clear = 1'b1;
         // An unacked request must keep its address on the bus; its ack is
         // swallowed and the redirected request follows it.
         kill_nxt   = (state == FETCH) && !Imem_Ack_IN;
         stale_nxt  = Imem_Addr_OUT;
      end else begin
         unique case (state)
            BOOT:  state_nxt = FETCH;
            FETCH: begin
               if (Imem_Ack_IN) begin
                  if (kill_q) begin
                     kill_nxt = 1'b0;
                  end else begin
                     pc_nxt = follow_pc;
                     if (STALL_IN) begin
                        skid_load = 1'b1;
                        state_nxt = HOLD;
                     end else begin
                        out_load  = 1'b1;
                     end
                  end
               end
            end
            HOLD: begin
               if (!STALL_IN && skid_valid) begin
                  out_from_skid = 1'b1;
                  skid_clear    = 1'b1;
                  state_nxt     = FETCH;
               end
            end
            default: state_nxt = BOOT;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state   <= BOOT;
         pc_q    <= word_align(RESET_PC);
         stale_q <= word_align(RESET_PC);
         kill_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc_q    <= pc_nxt;
         stale_q <= stale_nxt;
         kill_q  <= kill_nxt;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Instr_OUT_IF      <= NOP;
         Instr_PC_OUT_IF   <= '0;
         Valid_OUT_IF      <= 1'b0;
         Pred_Taken_OUT_IF <= 1'b0;
      end else if (out_drop) begin
         Valid_OUT_IF      <= 1'b0;
         Pred_Taken_OUT_IF <= 1'b0;
      end else if (out_load) begin
         Instr_OUT_IF      <= Imem_Data_IN;
         Instr_PC_OUT_IF   <= pc_q;
         Valid_OUT_IF      <= 1'b1;
         Pred_Taken_OUT_IF <= take_Branch_IN_IF;
      end else if (out_from_skid) begin
         Instr_OUT_IF      <= skid_data;
         Instr_PC_OUT_IF   <= skid_pc;
         Valid_OUT_IF      <= 1'b1;
         Pred_Taken_OUT_IF <= skid_pred;
      end else if (!STALL_IN) begin
         // consumer took the word; nothing new to present
         Valid_OUT_IF      <= 1'b0;
      end
   end

   fetch_skid_buf u_skid (
      .CLK        (CLK),
      .RESET      (RESET),
      .load       (skid_load),
      .clear      (skid_clear),
      .data       (Imem_Data_IN),
      .pc         (pc_q),
      .pred       (take_Branch_IN_IF),
      .held_valid (skid_valid),
      .held_data  (skid_data),
      .held_pc    (skid_pc),
      .held_pred  (skid_pred)
   );

   // Cycles the current request has waited without an ack.
   logic [7:0] lat_cnt;
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)                          lat_cnt <= '0;
      else if (!Imem_Req_OUT || Imem_Ack_IN) lat_cnt <= '0;
      else if (lat_cnt != 8'hFF)           lat_cnt <= lat_cnt + 8'd1;
   end

   a_imem_lat: assert property (@(posedge CLK) disable iff (!RESET)
      Imem_Req_OUT |-> (int'(lat_cnt) < IMEM_LAT_MAX));

   a_addr_stable: assert property (@(posedge CLK) disable iff (!RESET)
      (Imem_Req_OUT && !Imem_Ack_IN) |=> (Imem_Addr_OUT == $past(Imem_Addr_OUT)));

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios followed by random traffic,
// all checked against a transaction-style reference model.
module tb_fetch_pc_gen;
   import bp_pkg::*;

   localparam logic [31:0] RPC = 32'hBFC00000;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        take_Branch_IN_IF = 1'b0;
   logic [31:0] take_Alt_PC_IN_IF = '0;
   logic        FLUSH_IN = 1'b0;
   logic        STALL_IN = 1'b0;
   logic        Imem_Req_OUT;
   logic [31:0] Imem_Addr_OUT;
   logic        Imem_Ack_IN = 1'b0;
   logic [31:0] Imem_Data_IN = '0;
   logic [31:0] Instr_OUT_IF;
   logic [31:0] Instr_PC_OUT_IF;
   logic        Valid_OUT_IF;
   logic        Pred_Taken_OUT_IF;

   always #5 CLK = ~CLK;

   fetch_pc_gen #(.RESET_PC(RPC), .IMEM_LAT_MAX(8)) dut (
      .CLK               (CLK),
      .RESET             (RESET),
      .take_Branch_IN_IF (take_Branch_IN_IF),
      .take_Alt_PC_IN_IF (take_Alt_PC_IN_IF),
      .FLUSH_IN          (FLUSH_IN),
      .STALL_IN          (STALL_IN),
      .Imem_Req_OUT      (Imem_Req_OUT),
      .Imem_Addr_OUT     (Imem_Addr_OUT),
      .Imem_Ack_IN       (Imem_Ack_IN),
      .Imem_Data_IN      (Imem_Data_IN),
      .Instr_OUT_IF      (Instr_OUT_IF),
      .Instr_PC_OUT_IF   (Instr_PC_OUT_IF),
      .Valid_OUT_IF      (Valid_OUT_IF),
      .Pred_Taken_OUT_IF (Pred_Taken_OUT_IF)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // memory contents: a fixed scramble of the address
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h13572468;
   endfunction

   // ---------------- reference model ----------------
   typedef struct { logic [31:0] i; logic [31:0] pc; bit p; } word_t;
   word_t       park_q[$];
   bit          m_req, m_kill, o_v, o_p;
   logic [31:0] m_addr, m_next, o_i, o_pc;

   task automatic model_reset();
      m_req = 0; m_kill = 0; park_q.delete();
      o_v = 0; o_p = 0; o_i = '0; o_pc = '0;
      m_addr = RPC; m_next = RPC;
   endtask

   task automatic deliver(input word_t w);
      o_i = w.i; o_pc = w.pc; o_p = w.p; o_v = 1;
   endtask

   task automatic model_step(input bit st, input bit fl, input bit br,
                             input logic [31:0] alt, input bit ack, input logic [31:0] data);
      word_t w;
      logic [31:0] tgt;
      tgt = alt & ~32'h3;
      if (fl) begin
         o_v = 0; o_p = 0; park_q.delete(); m_next = tgt;
         if (m_req && !ack) m_kill = 1;
         else begin m_kill = 0; m_addr = m_next; end
         m_req = 1;
      end else if (m_req && ack && m_kill) begin
         m_kill = 0; m_addr = m_next;
         if (!st) o_v = 0;
      end else if (m_req && ack) begin
         w = '{data, m_addr, br};
         if (st) begin
            park_q.push_back(w); m_req = 0;
            m_next = br ? tgt : m_addr + 32'd4;
         end else begin
            deliver(w);
            m_addr = br ? tgt : m_addr + 32'd4;
         end
      end else if (park_q.size() != 0) begin
         if (!st) begin
            deliver(park_q.pop_front()); m_req = 1; m_addr = m_next;
         end
      end else begin
         m_req = 1;
         if (!st) o_v = 0;
      end
   endtask

   task automatic compare(input string w);
      chk({w, "/req"}, 32'(Imem_Req_OUT), 32'(m_req));
      if (m_req) chk({w, "/addr"}, Imem_Addr_OUT, m_addr);
      chk({w, "/valid"}, 32'(Valid_OUT_IF), 32'(o_v));
      if (o_v) begin
         chk({w, "/instr"}, Instr_OUT_IF, o_i);
         chk({w, "/ipc"}, Instr_PC_OUT_IF, o_pc);
         chk({w, "/pred"}, 32'(Pred_Taken_OUT_IF), 32'(o_p));
      end
   endtask

   // one clock: drive at negedge, model after posedge, check at next negedge
   task automatic step(input bit st, input bit fl, input bit br,
                       input logic [31:0] alt, input bit ack, input string tag);
      STALL_IN = st; FLUSH_IN = fl; take_Branch_IN_IF = br;
      take_Alt_PC_IN_IF = alt; Imem_Ack_IN = ack;
      Imem_Data_IN = ack ? mem(m_addr) : 32'hDEADBEEF;
      @(posedge CLK);
      model_step(st, fl, br, alt, ack, Imem_Data_IN);
      @(negedge CLK);
      compare(tag);
   endtask

   // request cycle, one wait cycle, ack two cycles after the request
   task automatic xfer(input bit br, input logic [31:0] alt, input string tag);
      step(0, 0, 0, 32'h0, 0, tag);
      step(0, 0, 0, 32'h0, 0, tag);
      step(0, 0, br, alt, 1, tag);
   endtask

   task automatic do_reset(input bit mid);
      if (mid) #2;
      STALL_IN = 0; FLUSH_IN = 0; take_Branch_IN_IF = 0; Imem_Ack_IN = 0;
      RESET = 1'b0;
      #1;
      chk("rst/req",   32'(Imem_Req_OUT), 32'd0);
      chk("rst/addr",  Imem_Addr_OUT, RPC);
      chk("rst/valid", 32'(Valid_OUT_IF), 32'd0);
      chk("rst/pred",  32'(Pred_Taken_OUT_IF), 32'd0);
      chk("rst/instr", Instr_OUT_IF, 32'd0);
      chk("rst/ipc",   Instr_PC_OUT_IF, 32'd0);
      model_reset();
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   logic [31:0] frz_pc, frz_i;
   int          mw, lat;
   bit          ack;

   initial begin
      @(negedge CLK);

      // sequential fetch, ack two cycles after each request
      do_reset(0);
      compare("boot");
      step(0, 0, 0, 32'h0, 0, "boot");
      xfer(0, 32'h0, "seq");
      chk("seq/pc0", Instr_PC_OUT_IF, 32'hBFC00000);
      chk("seq/addr1", Imem_Addr_OUT, 32'hBFC00004);
      xfer(0, 32'h0, "seq");
      chk("seq/pc1", Instr_PC_OUT_IF, 32'hBFC00004);
      chk("seq/addr2", Imem_Addr_OUT, 32'hBFC00008);
      xfer(0, 32'h0, "seq");
      chk("seq/pc2", Instr_PC_OUT_IF, 32'hBFC00008);

      // predicted-taken branch
      do_reset(0);
      step(0, 0, 0, 32'h0, 0, "boot");
      xfer(0, 32'h0, "br");
      xfer(1, 32'h00400100, "br");
      chk("br/addr", Imem_Addr_OUT, 32'h00400100);
      chk("br/pred", 32'(Pred_Taken_OUT_IF), 32'd1);
      chk("br/ipc", Instr_PC_OUT_IF, 32'hBFC00004);

      // stall for three cycles starting on the ack
      step(0, 0, 0, 32'h0, 0, "stall");
      step(0, 0, 0, 32'h0, 0, "stall");
      frz_pc = Instr_PC_OUT_IF; frz_i = Instr_OUT_IF;
      step(1, 0, 0, 32'h0, 1, "stall");
      step(1, 0, 0, 32'h0, 0, "stall");
      step(1, 0, 0, 32'h0, 0, "stall");
      chk("stall/req", 32'(Imem_Req_OUT), 32'd0);
      chk("stall/frz_pc", Instr_PC_OUT_IF, frz_pc);
      chk("stall/frz_i", Instr_OUT_IF, frz_i);
      step(0, 0, 0, 32'h0, 0, "stall");
      chk("stall/valid", 32'(Valid_OUT_IF), 32'd1);
      chk("stall/ipc", Instr_PC_OUT_IF, 32'h00400100);
      chk("stall/instr", Instr_OUT_IF, mem(32'h00400100));
      step(0, 0, 0, 32'h0, 0, "stall");
      chk("stall/nodup", 32'(Valid_OUT_IF), 32'd0);

      // flush while the request for BFC00010 is outstanding
      do_reset(0);
      step(0, 0, 0, 32'h0, 0, "boot");
      for (int k = 0; k < 4; k++) xfer(0, 32'h0, "kill");
      step(0, 0, 0, 32'h0, 0, "kill");
      step(0, 1, 0, 32'h00400200, 0, "kill");
      chk("kill/held", Imem_Addr_OUT, 32'hBFC00010);
      step(0, 0, 0, 32'h0, 1, "kill");
      chk("kill/valid", 32'(Valid_OUT_IF), 32'd0);
      chk("kill/addr", Imem_Addr_OUT, 32'h00400200);
      xfer(0, 32'h0, "kill");
      chk("kill/ipc", Instr_PC_OUT_IF, 32'h00400200);

      // flush and stall together while a word is parked
      step(0, 0, 0, 32'h0, 0, "hflush");
      step(1, 0, 0, 32'h0, 1, "hflush");
      step(1, 1, 0, 32'h00400300, 0, "hflush");
      chk("hflush/valid", 32'(Valid_OUT_IF), 32'd0);
      chk("hflush/addr", Imem_Addr_OUT, 32'h00400300);
      xfer(0, 32'h0, "hflush");
      chk("hflush/ipc", Instr_PC_OUT_IF, 32'h00400300);

      // reset mid-request, stray ack right after release
      step(0, 0, 0, 32'h0, 0, "mid");
      do_reset(1);
      step(0, 0, 0, 32'h0, 1, "stray");
      chk("stray/valid", 32'(Valid_OUT_IF), 32'd0);
      chk("stray/addr", Imem_Addr_OUT, RPC);
      xfer(0, 32'h0, "stray");
      chk("stray/ipc", Instr_PC_OUT_IF, RPC);

      // random traffic
      mw = 0; lat = $urandom_range(0, 3);
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset(1);
            mw = 0;
         end
         ack = 0;
         if (m_req) begin
            if (mw >= lat) begin ack = 1; mw = 0; lat = $urandom_range(0, 3); end
            else mw++;
         end else begin
            mw = 0;
         end
         step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 5) == 0, $urandom(), ack, "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000, is the first fetch address after reset.
REQ-002 Parameter IMEM_LAT_MAX, default 8, is the cycle bound used only by assertions on Imem_Ack_IN.
REQ-003 CLK  in  1  single clock; all state changes on posedge CLK.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 take_Branch_IN_IF  in  1  BTB predicts taken for the current fetch.
REQ-006 take_Alt_PC_IN_IF  in  32  BTB next-fetch address.
REQ-007 FLUSH_IN  in  1  BTB/ID mispredict; redirect to take_Alt_PC_IN_IF and kill younger work.
REQ-008 STALL_IN  in  1  IF/ID latch cannot accept an instruction this cycle.
REQ-009 Imem_Req_OUT  out  1  instruction-memory request valid.
REQ-010 Imem_Addr_OUT  out  32  request address, word aligned.
REQ-011 Imem_Ack_IN  in  1  one-cycle pulse: Imem_Data_IN is valid for the outstanding request.
REQ-012 Imem_Data_IN  in  32  fetched instruction word.
REQ-013 Instr_OUT_IF  out  32  instruction delivered to IF/ID.
REQ-014 Instr_PC_OUT_IF  out  32  PC of Instr_OUT_IF; this is the value driven to the BTB Instr_PC_IN_IF.
REQ-015 Valid_OUT_IF  out  1  Instr_OUT_IF/Instr_PC_OUT_IF are valid.
REQ-016 Pred_Taken_OUT_IF  out  1  take_Branch_IN_IF captured with this instruction, carried to ID.

Function
REQ-017 The FSM SHALL have states BOOT, FETCH, HOLD.
- BOOT: no request.
- FETCH: one request outstanding.
- HOLD: fetched word parked because of a stall.
REQ-018 BOOT SHALL go to FETCH on the first edge after reset deassertion, with fetch PC = RESET_PC.
REQ-019 In FETCH, Imem_Req_OUT SHALL be 1 and Imem_Addr_OUT = fetch PC, held stable until Imem_Ack_IN.
REQ-020 At most one request SHALL be outstanding at any time.
REQ-021 On Imem_Ack_IN with no kill and STALL_IN=0, the block SHALL register the instruction on the next edge:
- Instr_OUT_IF = Imem_Data_IN, Instr_PC_OUT_IF = fetch PC, Valid_OUT_IF = 1.
- Stay in FETCH; the next request is issued the following cycle.
- Fixed latency: 1 cycle from ack to Valid_OUT_IF.
REQ-022 On Imem_Ack_IN with STALL_IN=1, the block SHALL park the word in the skid buffer and enter HOLD; Imem_Req_OUT = 0 in HOLD.
REQ-023 In HOLD with STALL_IN=0, the block SHALL deliver the parked word on the next edge and return to FETCH.
REQ-024 While STALL_IN=1, Instr_OUT_IF, Instr_PC_OUT_IF, Valid_OUT_IF and Pred_Taken_OUT_IF SHALL hold their values.
REQ-025 Next fetch PC SHALL be take_Alt_PC_IN_IF if (take_Branch_IN_IF | FLUSH_IN), else fetch PC + 32'd4.
- Sampled on the delivery edge.
- Addition wraps modulo 2^32.
- Bits [1:0] are forced to 0.
REQ-026 FLUSH_IN=1 SHALL have priority over STALL_IN, ack and HOLD. On the next edge:
- Valid_OUT_IF = 0 and the skid buffer is emptied.
- Fetch PC = take_Alt_PC_IN_IF and the state goes to FETCH.
REQ-027 If FLUSH_IN arrives while a request is outstanding and unacked, the block SHALL set a kill flag and hold Imem_Addr_OUT.
- The matching ack is discarded.
- The redirected request issues the cycle after that ack.
REQ-028 FLUSH_IN coincident with Imem_Ack_IN SHALL discard that ack's data.
REQ-029 Repeated FLUSH_IN SHALL be honoured last-writer-wins: the PC from the most recent flush is used.
REQ-030 Pred_Taken_OUT_IF SHALL be take_Branch_IN_IF registered alongside Instr_PC_OUT_IF and cleared by flush.

Reset
REQ-031 Asserting RESET (low) at any time, including mid-request, SHALL asynchronously set:
- state = BOOT, fetch PC = RESET_PC.
- Imem_Req_OUT = 0, Imem_Addr_OUT = RESET_PC.
- Valid_OUT_IF = 0, Pred_Taken_OUT_IF = 0, Instr_OUT_IF = 0, Instr_PC_OUT_IF = 0.
- Kill flag = 0, skid buffer empty.
REQ-032 An Imem_Ack_IN arriving after reset for a pre-reset request SHALL be ignored; a request is outstanding only in FETCH.

Structure
REQ-033 The shared package bp_pkg SHALL hold the FSM state enum, PC width (32), the RESET_PC default and the instruction-word constant NOP = 32'h0.
REQ-034 The single-entry skid buffer SHALL be the sub-module fetch_skid_buf (data, PC, pred bit, valid); all other logic stays flat.

Verification
REQ-035 Reset release, ack 2 cycles after each request, STALL_IN=0 -> Imem_Addr_OUT sequence BFC00000, BFC00004, BFC00008; Valid_OUT_IF one cycle after each ack.
REQ-036 take_Branch_IN_IF=1, take_Alt_PC_IN_IF=0x00400100 on delivery of PC 0xBFC00004 -> next Imem_Addr_OUT = 0x00400100 and Pred_Taken_OUT_IF=1 with PC 0xBFC00004.
REQ-037 STALL_IN=1 for 3 cycles when ack arrives -> HOLD, Imem_Req_OUT=0, outputs frozen; delivery on the edge after STALL_IN falls, no word lost or duplicated.
REQ-038 FLUSH_IN=1 with Alt=0x00400200 one cycle after request for 0xBFC00010 -> ack data for 0xBFC00010 never appears with Valid_OUT_IF=1; next request address is 0x00400200.
REQ-039 FLUSH_IN and STALL_IN both 1 in HOLD -> Valid_OUT_IF=0 next cycle, skid empty, request to the Alt PC.
REQ-040 RESET low mid-request, stray ack after release -> no Valid_OUT_IF; first request is RESET_PC.
